// File: rtl/wheel_speed_pkg.sv
// wheel_speed_pkg: shared channel state encoding and default parameters for wheel speed capture
package wheel_speed_pkg;
  typedef enum logic [1:0] {WS_IDLE, WS_RUN, WS_STALL} ws_state_e;
  localparam int unsigned DEB_LEN_DEF = 4;
  localparam int unsigned PER_W_DEF   = 24;
  localparam int unsigned POS_W_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 5_000_000;
endpackage

// File: rtl/wheel_speed_ch.sv
// wheel_speed_ch: one encoder channel - synchroniser, debounce, rising-edge FSM, period timer, position
module wheel_speed_ch
  import wheel_speed_pkg::*;
#(
  parameter int unsigned DEB_LEN = DEB_LEN_DEF,
  parameter int unsigned PER_W   = PER_W_DEF,
  parameter int unsigned POS_W   = POS_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_sys,
  input  logic             rst_sys_n,
  input  logic             evnt,
  input  logic             dir,
  input  logic             clr,
  output logic [POS_W-1:0] pos,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             stall
);
  logic [1:0]       sync;
  logic             filt;
  logic             filt_prev;
  logic [7:0]       deb_cnt;
  logic [PER_W-1:0] timer;
  logic             ev;
  logic             hit;
  ws_state_e        state;
  ws_state_e        nxt;
  assign ev  = filt & ~filt_prev;
  assign hit = timer == PER_W'(TIMEOUT - 1);
  // Synchronise the raw pulse and only move the filtered level after DEB_LEN disagreeing samples
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) begin
      sync      <= '0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync      <= {sync[0], evnt};
      filt_prev <= filt;
      if (sync[1] == filt) deb_cnt <= '0;
      else if (deb_cnt == 8'(DEB_LEN - 1)) begin
        deb_cnt <= '0;
        filt    <= ~filt;
      end else deb_cnt <= deb_cnt + 8'd1;
    end
  // State register
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) state <= WS_IDLE;
    else state <= nxt;
  // Clear beats an edge, an edge beats the timeout
  always_comb
    nxt = clr ? WS_IDLE : ev ? WS_RUN : (state == WS_RUN && hit) ? WS_STALL : state;
  // Wheel is reported stalled whenever it is not actively being timed
  always_comb
    stall = state != WS_RUN;
  // Period timer, period result and signed position; the first edge after idle/stall only re-arms
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) begin
      timer      <= '0;
      pos        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= !clr && ev && state == WS_RUN;
      if (clr) begin
        timer  <= '0;
        pos    <= '0;
        period <= '0;
      end else if (ev) begin
        timer <= '0;
        pos   <= dir ? pos - POS_W'(1) : pos + POS_W'(1);
        if (state == WS_RUN) period <= timer + PER_W'(1);
      end else if (state == WS_RUN) begin
        if (hit) period <= '0;
        else timer <= timer + PER_W'(1);
      end
    end
endmodule

// File: rtl/wheel_speed_capture.sv
// wheel_speed_capture: per-wheel encoder conditioning, position and period capture with packed output buses
module wheel_speed_capture
  import wheel_speed_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned DEB_LEN = DEB_LEN_DEF,
  parameter int unsigned PER_W   = PER_W_DEF,
  parameter int unsigned POS_W   = POS_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys_n,
  input  logic [NUM_CH-1:0]       evnt_i,
  input  logic [NUM_CH-1:0]       dir_i,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH*POS_W-1:0] pos_o,
  output logic [NUM_CH*PER_W-1:0] period_o,
  output logic [NUM_CH-1:0]       period_vld_o,
  output logic [NUM_CH-1:0]       stall_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wheel_speed_ch #(
      .DEB_LEN(DEB_LEN),
      .PER_W  (PER_W),
      .POS_W  (POS_W),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .evnt      (evnt_i[i]),
      .dir       (dir_i[i]),
      .clr       (clr_i[i]),
      .pos       (pos_o[i*POS_W +: POS_W]),
      .period    (period_o[i*PER_W +: PER_W]),
      .period_vld(period_vld_o[i]),
      .stall     (stall_o[i])
    );
  end
endmodule

// File: tb/tb_wheel_speed_capture.sv
// tb_wheel_speed_capture: timestamp-based reference model with per-cycle compare plus literal scenario checks
module tb_wheel_speed_capture;
  localparam int D  = 4;
  localparam int T  = 1000;
  localparam int PW = 16;
  localparam int QW = 24;
  logic clk_sys = 1'b0;
  logic rst_sys_n = 1'b1;
  logic [1:0] evnt_i = '0;
  logic [1:0] dir_i = '0;
  logic [1:0] clr_i = '0;
  logic [2*PW-1:0] pos_o;
  logic [2*QW-1:0] period_o;
  logic [1:0] period_vld_o;
  logic [1:0] stall_o;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int vld_cnt [2] = '{0, 0};
  logic [D+1:0] sh [2];
  bit m_filt [2];
  bit m_rose [2];
  bit m_run [2];
  bit m_vld [2];
  int m_last [2];
  logic [PW-1:0] m_pos [2];
  logic [QW-1:0] m_per [2];

  wheel_speed_capture #(.NUM_CH(2), .DEB_LEN(D), .PER_W(QW), .POS_W(PW), .TIMEOUT(T)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .evnt_i(evnt_i), .dir_i(dir_i), .clr_i(clr_i),
    .pos_o(pos_o), .period_o(period_o), .period_vld_o(period_vld_o), .stall_o(stall_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse(input int c, input int hi, input int lo);
    evnt_i[c] = 1'b1;
    tick(hi);
    evnt_i[c] = 1'b0;
    tick(lo);
  endtask

  function automatic logic [PW-1:0] pos_of(input int c);
    return pos_o[c*PW +: PW];
  endfunction

  function automatic logic [QW-1:0] per_of(input int c);
    return period_o[c*QW +: QW];
  endfunction

  // Reference model: a level flips once the last D synchronised samples all disagree with it,
  // a rise becomes an event one edge later, periods are differences of event timestamps.
  initial forever begin
    @(posedge clk_sys);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (!rst_sys_n) begin
        sh[c] = '0; m_filt[c] = 0; m_rose[c] = 0; m_run[c] = 0; m_vld[c] = 0;
        m_last[c] = 0; m_pos[c] = '0; m_per[c] = '0;
      end else begin
        bit ev;
        ev = m_rose[c];
        m_rose[c] = 0;
        sh[c] = {sh[c][D:0], evnt_i[c]};
        if (sh[c][D+1:2] == {D{~m_filt[c]}}) begin
          m_filt[c] = ~m_filt[c];
          m_rose[c] = m_filt[c];
        end
        m_vld[c] = 0;
        if (clr_i[c]) begin
          m_run[c] = 0; m_pos[c] = '0; m_per[c] = '0;
        end else if (ev) begin
          if (m_run[c]) begin
            m_per[c] = QW'(cyc - m_last[c]);
            m_vld[c] = 1;
          end
          m_run[c] = 1;
          m_last[c] = cyc;
          m_pos[c] = dir_i[c] ? m_pos[c] - 1'b1 : m_pos[c] + 1'b1;
        end else if (m_run[c] && cyc - m_last[c] == T) begin
          m_run[c] = 0;
          m_per[c] = '0;
        end
      end
    end
  end

  // Per-cycle compare of every channel against the model
  initial forever begin
    @(negedge clk_sys);
    if (rst_sys_n) begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if ({pos_of(c), per_of(c), period_vld_o[c], stall_o[c]} != {m_pos[c], m_per[c], m_vld[c], !m_run[c]}) begin
          errs++;
          if (errs < 20)
            $display("FAIL cycle%0d ch%0d pos/per/vld/stall got=%0h/%0d/%0b/%0b expected=%0h/%0d/%0b/%0b",
                     cyc, c, pos_of(c), per_of(c), period_vld_o[c], stall_o[c],
                     m_pos[c], m_per[c], m_vld[c], !m_run[c]);
        end
        if (period_vld_o[c]) vld_cnt[c]++;
      end
    end
  end

  initial begin
    int k, lat, t, v;
    logic [PW-1:0] p1;
    #1 rst_sys_n = 1'b0;
    tick(3);
    rst_sys_n = 1'b1;
    tick(2000);
    chk("idle_stall", 64'(stall_o), 64'(2'b11));
    chk("idle_pos", 64'(pos_o), 64'd0);
    chk("idle_period", 64'(period_o), 64'd0);
    chk("idle_vld_cnt", 64'(vld_cnt[0] + vld_cnt[1]), 64'd0);

    evnt_i[0] = 1'b1;
    k = cyc + 1;
    lat = -1;
    t = 0;
    while (t < 20 && lat < 0) begin
      tick(1);
      t++;
      if (!stall_o[0]) lat = cyc - k;
    end
    chk("latency", 64'(lat), 64'(D + 2));
    tick(50 - t);
    evnt_i[0] = 1'b0;
    tick(150);
    chk("first_pos", 64'(pos_of(0)), 64'd1);
    chk("first_no_vld", 64'(vld_cnt[0]), 64'd0);
    chk("first_run", 64'(stall_o[0]), 64'd0);
    pulse(0, 50, 150);
    chk("second_period", 64'(per_of(0)), 64'd200);
    chk("second_vld_once", 64'(vld_cnt[0]), 64'd1);
    chk("second_pos", 64'(pos_of(0)), 64'd2);
    pulse(0, 50, 150);

    repeat (3) pulse(1, 3, 10);
    pulse(1, 5, 30);
    chk("glitch_pos", 64'(pos_of(1)), 64'd1);
    chk("glitch_no_vld", 64'(vld_cnt[1]), 64'd0);

    tick(1100);
    chk("timeout_stall", 64'(stall_o[0]), 64'd1);
    chk("timeout_period", 64'(per_of(0)), 64'd0);
    v = vld_cnt[0];
    pulse(0, 50, 250);
    chk("rearm_no_vld", 64'(vld_cnt[0]), 64'(v));
    chk("rearm_run", 64'(stall_o[0]), 64'd0);
    pulse(0, 50, 250);
    chk("rearm_period", 64'(per_of(0)), 64'd300);
    chk("rearm_vld", 64'(vld_cnt[0]), 64'(v + 1));

    clr_i[0] = 1'b1;
    tick(1);
    clr_i[0] = 1'b0;
    tick(2);
    chk("clr_pos", 64'(pos_of(0)), 64'd0);
    dir_i[0] = 1'b1;
    repeat (3) pulse(0, 8, 12);
    chk("reverse_pos", 64'(pos_of(0)), 64'hFFFD);
    tick(5);
    #2;
    force dut.g_ch[0].u_ch.pos = 16'h7FFF;
    m_pos[0] = 16'h7FFF;
    tick(1);
    #2;
    release dut.g_ch[0].u_ch.pos;
    tick(1);
    dir_i[0] = 1'b0;
    pulse(0, 8, 12);
    chk("wrap_pos", 64'(pos_of(0)), 64'h8000);

    pulse(0, 8, 12);
    pulse(0, 8, 12);
    p1 = pos_of(1);
    v = vld_cnt[0];
    evnt_i[0] = 1'b1;
    tick(D + 2);
    clr_i[0] = 1'b1;
    tick(1);
    clr_i[0] = 1'b0;
    tick(13);
    evnt_i[0] = 1'b0;
    tick(12);
    chk("clr_evt_pos", 64'(pos_of(0)), 64'd0);
    chk("clr_evt_stall", 64'(stall_o[0]), 64'd1);
    chk("clr_evt_no_vld", 64'(vld_cnt[0]), 64'(v));
    chk("clr_evt_ch1", 64'(pos_of(1)), 64'(p1));

    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(i < 2000 ? 5 : 399) == 0) evnt_i[c] = ~evnt_i[c];
        if ($urandom_range(15) == 0) dir_i[c] = 1'($urandom_range(1));
        clr_i[c] = $urandom_range(299) == 0;
      end
      if (i == 2500) begin
        #2 rst_sys_n = 1'b0;
      end
      if (i == 2503) begin
        #2 rst_sys_n = 1'b1;
      end
      tick(1);
    end
    clr_i = '0;
    tick(5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/wheel_speed_capture.md
Name: wheel_speed_capture

Overview:
- Feedback path for the two-wheel platform: the motor drive sends PWM and direction out to the H-bridges, and this block takes the wheel-encoder pulses (Evnt) back in.
- For each wheel it synchronises and debounces the encoder input, detects rising edges, and keeps a signed position count that follows the commanded direction.
- It measures the period between edges in clk_sys cycles and flags a stalled wheel.
- Outputs are flat registers sampled by the ibex_sys peripheral logic.

Parameters:
- NUM_CH, 2, number of encoder channels.
- DEB_LEN, 4, consecutive stable samples required to change the filtered level (legal range 1..255).
- PER_W, 24, period measurement width in bits.
- POS_W, 16, position counter width in bits.
- TIMEOUT, 24'd5_000_000, cycles with no edge before stall is declared. Must satisfy 2 ≤ TIMEOUT < 2^PER_W.

Ports:
- clk_sys, input, 1, system clock.
- rst_sys_n, input, 1, asynchronous active-low reset.
- evnt_i, input, NUM_CH, raw encoder pulses; asynchronous to clk_sys.
- dir_i, input, NUM_CH, commanded direction: 0 = forward (count up), 1 = reverse (count down).
- clr_i, input, NUM_CH, per-channel synchronous clear pulse.
- pos_o, output, NUM_CH*POS_W, signed position count per channel.
- period_o, output, NUM_CH*PER_W, last measured edge-to-edge period in cycles.
- period_vld_o, output, NUM_CH, one-cycle strobe when period_o updates.
- stall_o, output, NUM_CH, level signal: wheel stalled or not yet moving.

Behaviour:
- Reset (async assert, sync release): all outputs 0 except stall_o = 1. Synchronisers, filter and timer = 0. State = IDLE.
- Input conditioning, per channel:
  - 2-FF synchroniser.
  - Debounce counter counts cycles where sync2 differs from filt_q. When it reaches DEB_LEN, filt_q toggles and the counter clears. Any matching sample clears the counter.
- Edge detection: event = filt_q & ~filt_prev_q. Only rising edges count.
- Latency: evnt_i first sampled high at edge k (and held stable) → state, pos_o and period_o update at edge k+DEB_LEN+2. This latency is fixed.
- Glitch rejection: a pulse shorter than DEB_LEN cycles after synchronisation produces no event.
- State machine, per channel:
  - IDLE (stall_o = 1):
    - event → RUN; timer = 0; pos updated; no period_vld.
  - RUN (stall_o = 0):
    - timer increments each cycle.
    - event → period_o = timer+1; period_vld_o = 1 for one cycle; timer = 0; pos updated.
    - timer == TIMEOUT-1 with no event → STALL; period_o = 0; stall_o = 1.
  - STALL (stall_o = 1):
    - timer held.
    - event → RUN; timer = 0; pos updated; no period_vld. The first edge only re-arms the measurement.
- Period definition: edges at cycles t and t+N give period_o = N.
- Position update: pos += 1 if dir_i = 0, pos -= 1 if dir_i = 1, with dir_i sampled in the event cycle. Two's-complement wrap: 0x7FFF+1 = 0x8000, 0x0000-1 = 0xFFFF. No saturation.
- clr_i:
  - Next edge: pos = 0, period_o = 0, timer = 0, state = IDLE, stall_o = 1.
  - Takes priority over a same-cycle event; that event is discarded.
  - Does not reset the synchroniser or filter.
- Same-cycle event and timeout: event wins, and a valid period of TIMEOUT is reported.
- Channels are fully independent.
- dir_i changes between edges take effect only at the next event.
- Reset mid-operation: immediate return to reset values. Any partial debounce is lost.

Decomposition:
- Package wheel_speed_pkg:
  - State enum ws_state_e {WS_IDLE, WS_RUN, WS_STALL}, 2 bits.
  - Default constants: DEB_LEN_DEF, PER_W_DEF, POS_W_DEF, TIMEOUT_DEF.
- Sub-module wheel_speed_ch: one channel (synchroniser, debounce, FSM, timer, position). The top instantiates NUM_CH copies in a generate loop and packs the output buses.

Test Plan (bench: DEB_LEN = 4, TIMEOUT = 1000):
- Reset, then evnt_i[0] stays low for 2000 cycles → all outputs 0, stall_o = 2'b11, no period_vld.
- Clean rising edges on ch0 every 200 cycles (high 50 cycles), dir_i = 0 → first edge: pos = 1, no vld, stall_o[0] = 0. Second edge: period_o = 200, single-cycle vld, pos = 2. Measure latency = DEB_LEN+2 = 6 cycles from first high sample.
- 3-cycle glitches on ch1 plus one 5-cycle pulse → only the 5-cycle pulse counts; pos[1] = 1.
- ch0 running, then no edges → exactly 1000 cycles after the last edge: stall_o[0] = 1, period_o = 0. Next edge: no vld. Edge after that (300 cycles later): period_o = 300.
- dir_i[0] = 1 from pos = 0, 3 edges → pos = 0xFFFD. Preload to 0x7FFF and go forward → wraps to 0x8000.
- clr_i[0] asserted in the same cycle as an event → pos = 0, state IDLE, no vld, stall_o[0] = 1. ch1 unaffected.
